// File: rtl/rtclock_regs_mc.sv
// AXI4-Lite register block for multi-channel 64-bit real-time clocks.
// Provides ID/VERSION/FLIP/CONTROL, and per-channel windows holding a
// two-step committed configuration plus a tearing-free state snapshot.
module rtclock_regs_mc #(
  parameter int          ADDR_WIDTH    = 12,
  parameter int          NUM_CH        = 2,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter logic [31:0] ID_VALUE      = 32'h52544331,
  parameter logic [31:0] VERSION_VALUE = 32'h00020000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             control,
  output logic [64*NUM_CH-1:0]    cfg_value,
  output logic [NUM_CH-1:0]       cfg_load,
  input  logic [64*NUM_CH-1:0]    state_value
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Register kinds: low window 0..3, channel window 4..7.
  localparam logic [2:0] K_ID    = 3'd0;
  localparam logic [2:0] K_VER   = 3'd1;
  localparam logic [2:0] K_FLIP  = 3'd2;
  localparam logic [2:0] K_CTRL  = 3'd3;
  localparam logic [2:0] K_CFGHI = 3'd4;
  localparam logic [2:0] K_CFGLO = 3'd5;
  localparam logic [2:0] K_STHI  = 3'd6;
  localparam logic [2:0] K_STLO  = 3'd7;

  // Word address -> {mapped, kind, channel}.
  function automatic logic [6:0] decode(input logic [ADDR_WIDTH-3:0] w);
    logic [29:0] d;
    logic        v;
    logic [2:0]  k;
    logic [2:0]  ch;
    d  = 30'(w);
    v  = 1'b0;
    k  = 3'd0;
    ch = 3'd0;
    if (d[29:2] == 28'd0) begin
      v = 1'b1;
      k = {1'b0, d[1:0]};
    end else if (d[29:5] == 25'd2 && int'(d[4:2]) < NUM_CH) begin
      v  = 1'b1;
      ch = d[4:2];
      k  = {1'b1, d[1:0]};
    end
    return {v, k, ch};
  endfunction

  // Byte-lane merge of a write into an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  logic [0:0]  wstate_q, rstate_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] control_q, flip_q;
  logic [63:0] cfg_q  [NUM_CH];
  logic [31:0] stg_q  [NUM_CH];
  logic [31:0] snap_q [NUM_CH];
  logic [NUM_CH-1:0] load_q, load_d;

  logic        wv, rv;
  logic [2:0]  wk, wch, rk, rch;
  logic        wr_fire, rd_fire, wr_ok;
  logic        unused_lsbs;

  assign {wv, wk, wch} = decode(s_axi_awaddr[ADDR_WIDTH-1:2] ^ BASE_ADDR[ADDR_WIDTH-1:2]);
  assign {rv, rk, rch} = decode(s_axi_araddr[ADDR_WIDTH-1:2] ^ BASE_ADDR[ADDR_WIDTH-1:2]);
  assign unused_lsbs   = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Handshakes complete in the same cycle the request is seen while idle.
  assign wr_fire = resetn && (wstate_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = resetn && (rstate_q == R_IDLE) && s_axi_arvalid;
  assign wr_ok   = wv && (wk == K_FLIP || wk == K_CTRL || wk == K_CFGHI || wk == K_CFGLO);

  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_arready = rd_fire;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign control       = control_q;
  assign cfg_load      = load_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cfg_out
    assign cfg_value[64*g +: 64] = cfg_q[g];
  end

  // Write response FSM: one outstanding write, held until bready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate_q <= W_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (wstate_q == W_IDLE) begin
      if (wr_fire) begin
        wstate_q <= W_RESP;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? 2'b00 : 2'b10;
      end
    end else if (s_axi_bready) begin
      wstate_q <= W_IDLE;
      bvalid_q <= 1'b0;
    end
  end

  // Commit pulse for each channel whose CFG_LO is written this cycle.
  always_comb begin
    load_d = '0;
    for (int c = 0; c < NUM_CH; c++)
      load_d[c] = wr_fire && wr_ok && (wk == K_CFGLO) && (wch == 3'(c));
  end

  // Writable registers; CFG_LO commits the staged upper word atomically.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      control_q <= '0;
      flip_q    <= '0;
      load_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_q[c] <= '0;
        stg_q[c] <= '0;
      end
    end else begin
      load_q <= load_d;
      if (wr_fire && wr_ok) begin
        case (wk)
          K_FLIP:  flip_q    <= merge(flip_q, s_axi_wdata, s_axi_wstrb);
          K_CTRL:  control_q <= merge(control_q, s_axi_wdata, s_axi_wstrb);
          default: begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (wch == 3'(c)) begin
                if (wk == K_CFGHI)
                  stg_q[c] <= merge(stg_q[c], s_axi_wdata, s_axi_wstrb);
                else
                  cfg_q[c] <= {stg_q[c], merge(cfg_q[c][31:0], s_axi_wdata, s_axi_wstrb)};
              end
            end
          end
        endcase
      end
    end
  end

  // Read data mux; uses current register contents so a concurrent write is not visible.
  always_comb begin
    rdata_d = 32'hDEADBEEF;
    rresp_d = 2'b10;
    if (rv) begin
      rresp_d = 2'b00;
      case (rk)
        K_ID:    rdata_d = ID_VALUE;
        K_VER:   rdata_d = VERSION_VALUE;
        K_FLIP:  rdata_d = ~flip_q;
        K_CTRL:  rdata_d = control_q;
        default: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (rch == 3'(c)) begin
              case (rk)
                K_CFGHI: rdata_d = cfg_q[c][63:32];
                K_CFGLO: rdata_d = cfg_q[c][31:0];
                K_STHI:  rdata_d = state_value[64*c+32 +: 32];
                default: rdata_d = snap_q[c];
              endcase
            end
          end
        end
      endcase
    end
  end

  // STATE_HI returns the live upper word, so only the low word needs holding for STATE_LO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) snap_q[c] <= '0;
    end else if (rd_fire && rv && rk == K_STHI) begin
      for (int c = 0; c < NUM_CH; c++)
        if (rch == 3'(c)) snap_q[c] <= state_value[64*c +: 32];
    end
  end

  // Read FSM: capture data at arready, hold until rready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (rstate_q == R_IDLE) begin
      if (rd_fire) begin
        rstate_q <= R_DATA;
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end
    end else if (s_axi_rready) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
    end
  end

endmodule
